// File: rtl/lm07_pkg.sv
// Shared definitions for the LM70/LM07 SPI temperature sequencer:
// controller states and the default frame/timing constants.
package lm07_pkg;

   localparam int LM07_DATA_BITS = 16;
   localparam int LM07_SCK_DIV   = 2;
   localparam int LM07_CS_SETUP  = 2;
   localparam int LM07_INTERVAL  = 1000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4,
      WAIT  = 3'd5
   } lm07_state_e;

endpackage

// File: rtl/lm07_sck_gen.sv
// SCK generator for the LM07 sequencer. While run is high it produces
// DATA_BITS clock periods of 2*SCK_DIV cycles each, low half first, and
// flags the cycles whose closing edge raises or drops SCK. last_fall marks
// the falling edge that completes the final bit of the frame.
module lm07_sck_gen
   import lm07_pkg::*;
#(
   parameter int DATA_BITS = LM07_DATA_BITS,
   parameter int SCK_DIV   = LM07_SCK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic sck,
   output logic rise_stb,
   output logic fall_stb,
   output logic last_fall
);

   localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt;
   logic          half_end;

   assign half_end  = run && (div_cnt == DIV_LAST);
   assign rise_stb  = half_end && !sck;
   assign fall_stb  = half_end && sck;
   assign last_fall = fall_stb && (bit_cnt == BIT_LAST);

   // Divide clk into SCK half-periods; SCK is a flop so it never glitches,
   // and everything returns to idle-low whenever run drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         sck     <= 1'b0;
      end else if (!run) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         sck     <= 1'b0;
      end else if (half_end) begin
         div_cnt <= '0;
         sck     <= ~sck;
         if (sck) begin
            bit_cnt <= bit_cnt + BW'(1);
         end
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

endmodule

// File: rtl/lm07_spi_sequencer.sv
// LM70/LM07 SPI read sequencer. Frames are started by a one-shot start
// (queued one deep while busy) or by a free-running interval timer, the
// frame is shifted in MSB first, and the captured word is offered to the
// display datapath over a valid/ack handshake with a sticky overrun flag.
module lm07_spi_sequencer
   import lm07_pkg::*;
#(
   parameter int DATA_BITS = LM07_DATA_BITS,
   parameter int SCK_DIV   = LM07_SCK_DIV,
   parameter int CS_SETUP  = LM07_CS_SETUP,
   parameter int INTERVAL  = LM07_INTERVAL
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 start,
   input  logic                 auto_en,
   input  logic                 sio,
   output logic                 cs_n,
   output logic                 sck,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ack,
   output logic                 busy,
   output logic                 overrun
);

   localparam int TW = $clog2(CS_SETUP + 2);
   localparam int IW = $clog2(INTERVAL + 1);
   localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
   localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_SETUP);
   localparam logic [IW-1:0] ICNT_MAX   = IW'(INTERVAL - 1);

   lm07_state_e          state;
   lm07_state_e          next_state;
   logic [TW-1:0]        tcnt;
   logic [IW-1:0]        icnt;
   logic                 pending;
   logic [DATA_BITS-1:0] shreg;
   logic                 cs_n_d;
   logic                 trigger;
   logic                 icnt_expired;
   logic                 wait_exit;
   logic                 accept;
   logic                 run;
   logic                 sck_rise;
   logic                 sck_fall;
   logic                 sck_last;

   assign icnt_expired = (icnt == ICNT_MAX);
   assign trigger      = ena && (start || pending || (auto_en && icnt_expired));
   // WAIT hands over to IDLE one count early so that IDLE sees the
   // saturated counter and the auto trigger lands exactly INTERVAL cycles
   // after the frame ends.
   assign wait_exit    = icnt_expired || ((icnt + IW'(1)) == ICNT_MAX);
   assign accept       = data_ack && data_valid;
   assign run          = (state == SHIFT);
   assign busy         = (state != IDLE);

   lm07_sck_gen #(
      .DATA_BITS (DATA_BITS),
      .SCK_DIV   (SCK_DIV)
   ) u_sck_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .sck       (sck),
      .rise_stb  (sck_rise),
      .fall_stb  (sck_fall),
      .last_fall (sck_last)
   );

   // Next-state decode plus the value chip select takes after this edge;
   // HOLD raises cs_n for its final cycle so the sensor sees the release
   // before the word is published.
   always_comb begin
      next_state = state;
      cs_n_d     = 1'b1;
      case (state)
         IDLE:    if (trigger) next_state = SETUP;
         SETUP:   if (tcnt == SETUP_LAST) next_state = SHIFT;
         SHIFT:   if (sck_fall && sck_last) next_state = HOLD;
         HOLD:    if (tcnt == HOLD_LAST) next_state = DONE;
         DONE:    next_state = WAIT;
         WAIT:    if (pending || wait_exit) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      case (next_state)
         SETUP, SHIFT: cs_n_d = 1'b0;
         HOLD:         cs_n_d = (state == HOLD) && (tcnt == SETUP_LAST);
         default:      cs_n_d = 1'b1;
      endcase
   end

   // State register and registered chip select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cs_n  <= 1'b1;
      end else begin
         state <= next_state;
         cs_n  <= cs_n_d;
      end
   end

   // Dwell counter for the CS setup and hold phases, restarted on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= '0;
      end else if (next_state != state) begin
         tcnt <= '0;
      end else if ((state == SETUP) || (state == HOLD)) begin
         tcnt <= tcnt + TW'(1);
      end
   end

   // Interval timer: cleared when a frame starts, runs between frames and parks at its last count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         icnt <= '0;
      end else if ((state == IDLE) && trigger) begin
         icnt <= '0;
      end else if (((state == IDLE) || (state == WAIT)) && !icnt_expired) begin
         icnt <= icnt + IW'(1);
      end
   end

   // Single-deep start queue for requests that arrive while a frame is in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if ((state == IDLE) && (next_state == SETUP)) begin
         pending <= 1'b0;
      end else if (ena && start && busy) begin
         pending <= 1'b1;
      end
   end

   // Shift the sensor bit in on every SCK rising edge, MSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
      end else if (sck_rise) begin
         shreg <= {shreg[DATA_BITS-2:0], sio};
      end
   end

   // Publish the word in DONE and run the consumer handshake; an unacked word that gets replaced flags overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (state == DONE) begin
         data_out   <= shreg;
         data_valid <= 1'b1;
         if (data_valid && !data_ack) begin
            overrun <= 1'b1;
         end else if (accept) begin
            overrun <= 1'b0;
         end
      end else if (accept) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lm07_spi_sequencer.sv
// Self-checking bench for lm07_spi_sequencer at default parameters.
// A sensor model drives sio from a chosen 16-bit word; a monitor tracks
// cs_n/sck activity so frame length, SCK count/period and the spacing of
// frames can be compared with hand-computed values.
module tb_lm07_spi_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        start;
   logic        auto_en;
   logic        sio;
   logic        cs_n;
   logic        sck;
   logic [15:0] data_out;
   logic        data_valid;
   logic        data_ack;
   logic        busy;
   logic        overrun;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] model_word = 16'h0000;
   int          cyc        = 0;
   int          fall_count = 0;
   int          fall_cyc   = 0;
   int          low_len    = 0;
   int          sck_rises  = 0;
   int          bad_period = 0;
   int          last_rise  = -1;
   logic        prev_cs    = 1'b1;
   logic        prev_sck   = 1'b0;

   typedef struct {
      logic [15:0] word;
      logic [15:0] exp_data;
      logic        exp_overrun;
      logic        do_ack;
   } vec_t;

   vec_t vecs[6];

   lm07_spi_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .start      (start),
      .auto_en    (auto_en),
      .sio        (sio),
      .cs_n       (cs_n),
      .sck        (sck),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ack   (data_ack),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Sensor model and bus monitor, sampled on the falling clock edge.
   always @(negedge clk) begin
      cyc++;
      if (!cs_n && prev_cs) begin
         fall_count++;
         fall_cyc   = cyc;
         low_len    = 0;
         sck_rises  = 0;
         bad_period = 0;
         last_rise  = -1;
      end
      if (!cs_n) low_len++;
      if (!cs_n && sck && !prev_sck) begin
         sck_rises++;
         if (last_rise >= 0 && (cyc - last_rise) != 4) bad_period++;
         last_rise = cyc;
      end
      sio      = (!cs_n && sck_rises < 16) ? model_word[15 - sck_rises] : 1'b0;
      prev_cs  = cs_n;
      prev_sck = sck;
   end

   // Safety net in case a DUT fault stalls the whole run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no summary, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic s, input logic a, input logic k);
      ena      = e;
      start    = s;
      auto_en  = a;
      data_ack = k;
      tick();
   endtask

   task automatic pulseStart();
      applyStimulus(ena, 1'b1, auto_en, 1'b0);
      start = 1'b0;
   endtask

   task automatic pulseAck();
      applyStimulus(ena, 1'b0, auto_en, 1'b1);
      data_ack = 1'b0;
   endtask

   task automatic waitFallSince(input string name, input int base, input int budget);
      bit ok = (fall_count != base);
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (fall_count != base) ok = 1'b1;
      end
      compared++;
      if (!ok) begin
         mismatched++;
         $display("[TB] FAIL %s: no cs_n fall within %0d cycles, expected one", name, budget);
      end
   endtask

   task automatic waitCsRise(input string name, input int budget);
      bit ok = (cs_n === 1'b1);
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (cs_n === 1'b1) ok = 1'b1;
      end
      compared++;
      if (!ok) begin
         mismatched++;
         $display("[TB] FAIL %s: cs_n still low after %0d cycles, expected high", name, budget);
      end
   endtask

   initial begin
      int base;
      int f1;
      int fc[3];

      vecs[0] = '{16'h1234, 16'h1234, 1'b0, 1'b0};
      vecs[1] = '{16'hBEEF, 16'hBEEF, 1'b1, 1'b1};
      vecs[2] = '{16'h0001, 16'h0001, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1};

      rst_n    = 1'b0;
      ena      = 1'b1;
      start    = 1'b0;
      auto_en  = 1'b0;
      data_ack = 1'b0;
      ticks(3);
      checkOutput("rst_cs_n", cs_n, 1);
      checkOutput("rst_sck", sck, 0);
      checkOutput("rst_data_out", data_out, 0);
      checkOutput("rst_valid", data_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      ticks(2);

      $display("[TB] test 1: single start, word A5C3");
      model_word = 16'hA5C3;
      base = fall_count;
      pulseStart();
      checkOutput("t1_cs_latency", cs_n, 0);
      checkOutput("t1_busy", busy, 1);
      waitFallSince("t1_fall", base, 5);
      waitCsRise("t1_rise", 200);
      checkOutput("t1_cs_low_len", low_len, 68);
      checkOutput("t1_sck_pulses", sck_rises, 16);
      checkOutput("t1_sck_period", bad_period, 0);
      tick();
      checkOutput("t1_valid_plus1", data_valid, 0);
      tick();
      checkOutput("t1_valid_plus2", data_valid, 1);
      checkOutput("t1_data", data_out, 16'hA5C3);
      pulseAck();
      checkOutput("t1_ack_valid", data_valid, 0);

      $display("[TB] vector table: start-triggered frames with handshake");
      for (int i = 0; i < 6; i++) begin
         model_word = vecs[i].word;
         base = fall_count;
         pulseStart();
         waitFallSince($sformatf("vec%0d_fall", i), base, 20);
         waitCsRise($sformatf("vec%0d_rise", i), 200);
         ticks(2);
         checkOutput($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
         checkOutput($sformatf("vec%0d_valid", i), data_valid, 1);
         checkOutput($sformatf("vec%0d_overrun", i), overrun, vecs[i].exp_overrun);
         if (vecs[i].do_ack) begin
            pulseAck();
            checkOutput($sformatf("vec%0d_ack_valid", i), data_valid, 0);
            checkOutput($sformatf("vec%0d_ack_overrun", i), overrun, 0);
         end
      end

      $display("[TB] test 2: auto frames, ack 3 cycles after valid");
      model_word = 16'h5A5A;
      auto_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         base = fall_count;
         waitFallSince($sformatf("t2_fall%0d", k), base, 1200);
         fc[k] = fall_cyc;
         waitCsRise($sformatf("t2_rise%0d", k), 200);
         ticks(2);
         checkOutput($sformatf("t2_data%0d", k), data_out, 16'h5A5A);
         ticks(3);
         pulseAck();
         checkOutput($sformatf("t2_overrun%0d", k), overrun, 0);
      end
      auto_en = 1'b0;
      checkOutput("t2_spacing01", fc[1] - fc[0], 1070);
      checkOutput("t2_spacing12", fc[2] - fc[1], 1070);

      $display("[TB] test 3: two auto frames without ack");
      model_word = 16'h0012;
      auto_en = 1'b1;
      base = fall_count;
      waitFallSince("t3_fall0", base, 1200);
      waitCsRise("t3_rise0", 200);
      ticks(2);
      checkOutput("t3_data0", data_out, 16'h0012);
      checkOutput("t3_overrun0", overrun, 0);
      model_word = 16'h0034;
      base = fall_count;
      waitFallSince("t3_fall1", base, 1200);
      waitCsRise("t3_rise1", 200);
      ticks(2);
      auto_en = 1'b0;
      checkOutput("t3_data1", data_out, 16'h0034);
      checkOutput("t3_valid1", data_valid, 1);
      checkOutput("t3_overrun1", overrun, 1);
      pulseAck();
      checkOutput("t3_ack_valid", data_valid, 0);
      checkOutput("t3_ack_overrun", overrun, 0);

      $display("[TB] test 4: starts during SHIFT queue exactly one frame");
      model_word = 16'h0F0F;
      base = fall_count;
      pulseStart();
      waitFallSince("t4_fall0", base, 20);
      f1 = fall_cyc;
      ticks(11);
      pulseStart();
      ticks(5);
      pulseStart();
      ticks(5);
      pulseStart();
      ticks(5);
      pulseStart();
      waitCsRise("t4_rise0", 200);
      ticks(2);
      checkOutput("t4_data0", data_out, 16'h0F0F);
      model_word = 16'hF0F0;
      base = fall_count;
      waitFallSince("t4_fall1", base, 20);
      checkOutput("t4_extra_spacing", fall_cyc - f1, 72);
      waitCsRise("t4_rise1", 200);
      ticks(2);
      checkOutput("t4_data1", data_out, 16'hF0F0);
      checkOutput("t4_overrun", overrun, 1);
      base = fall_count;
      ticks(1500);
      checkOutput("t4_single_extra", fall_count, base);

      $display("[TB] start with ena low is ignored");
      ena = 1'b0;
      base = fall_count;
      pulseStart();
      ticks(20);
      ena = 1'b1;
      ticks(30);
      checkOutput("ena_low_start_ignored", fall_count, base);

      $display("[TB] test 5: async reset mid-frame");
      model_word = 16'hC3C3;
      base = fall_count;
      pulseStart();
      waitFallSince("t5_fall0", base, 20);
      for (int i = 0; i < 100 && sck_rises < 7; i++) tick();
      checkOutput("t5_reached_bit7", sck_rises, 7);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_async_cs_n", cs_n, 1);
      checkOutput("t5_async_sck", sck, 0);
      checkOutput("t5_async_valid", data_valid, 0);
      checkOutput("t5_async_overrun", overrun, 0);
      checkOutput("t5_async_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      tick();
      model_word = 16'h3C96;
      base = fall_count;
      pulseStart();
      waitFallSince("t5_fall1", base, 5);
      waitCsRise("t5_rise1", 200);
      checkOutput("t5_cs_low_len", low_len, 68);
      checkOutput("t5_sck_pulses", sck_rises, 16);
      ticks(2);
      checkOutput("t5_data", data_out, 16'h3C96);
      checkOutput("t5_valid", data_valid, 1);
      pulseAck();

      $display("[TB] test 6: ena dropped mid-frame with auto_en");
      model_word = 16'h7E81;
      auto_en = 1'b1;
      base = fall_count;
      pulseStart();
      waitFallSince("t6_fall", base, 20);
      ticks(20);
      ena = 1'b0;
      waitCsRise("t6_rise", 200);
      ticks(2);
      checkOutput("t6_data", data_out, 16'h7E81);
      checkOutput("t6_valid", data_valid, 1);
      base = fall_count;
      ticks(3000);
      checkOutput("t6_no_frames", fall_count, base);
      checkOutput("t6_cs_n_idle", cs_n, 1);
      checkOutput("t6_parked", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
